// File: rtl/fp_cmac_accumulator_if.sv
`default_nettype none
// ============================================================================
// fp_cmac_accumulator_if
// Product stream in / complex sum out handshake bundle for the accumulator.
// Revision: 1.0
// ============================================================================
interface fp_cmac_accumulator_if #(
   parameter int N   = 32,
   parameter int LEN = 8,
   parameter int CW  = $clog2(LEN + 1)
);
   logic          recv_val;
   logic          recv_rdy;
   logic          recv_last;
   logic [N-1:0]  xr;
   logic [N-1:0]  xc;
   logic          send_val;
   logic          send_rdy;
   logic [N-1:0]  sr;
   logic [N-1:0]  sc;
   logic [CW-1:0] send_cnt;

   modport master (
      output recv_val, recv_last, xr, xc, send_rdy,
      input  recv_rdy, send_val, sr, sc, send_cnt
   );

   modport slave (
      input  recv_val, recv_last, xr, xc, send_rdy,
      output recv_rdy, send_val, sr, sc, send_cnt
   );
endinterface
`default_nettype wire

// File: rtl/fp_cmac_accumulator.sv
`default_nettype none
// ============================================================================
// fp_cmac_accumulator
// Sums up to LEN complex products per block, optional saturating add.
// Revision: 1.0
// ============================================================================
module fp_cmac_accumulator #(
   parameter int N   = 32,
   parameter int LEN = 8,
   parameter int SAT = 1
) (
   input wire logic              clk,
   input wire logic              reset,
   fp_cmac_accumulator_if.slave  io
);
   localparam int CW = $clog2(LEN + 1);

   typedef enum logic [0:0] {
      ACC  = 1'b0,
      DONE = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  accr_q, accr_d;
   logic [N-1:0]  accc_q, accc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          recv_rdy_q, send_val_q;
   logic [CW-1:0] cnt_inc;

   // Overflow only possible when both operands share a sign the sum lost.
   function automatic logic [N-1:0] add_fn(input logic [N-1:0] a, input logic [N-1:0] b);
      logic [N-1:0] s;
      s = a + b;
      if ((SAT != 0) && (a[N-1] == b[N-1]) && (s[N-1] != a[N-1])) begin
         s = a[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
      end
      return s;
   endfunction

   assign cnt_inc = cnt_q + CW'(1);

   always_comb begin
      state_d = state_q;
      accr_d  = accr_q;
      accc_d  = accc_q;
      cnt_d   = cnt_q;
      case (state_q)
         ACC: begin
            if (io.recv_val) begin
               accr_d = add_fn(accr_q, io.xr);
               accc_d = add_fn(accc_q, io.xc);
               cnt_d  = cnt_inc;
               if ((cnt_inc == CW'(LEN)) || io.recv_last) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (io.send_rdy) begin
               accr_d  = '0;
               accc_d  = '0;
               cnt_d   = '0;
               state_d = ACC;
            end
         end
         default: state_d = ACC;
      endcase
   end

   // Handshake outputs are registered copies of the next state decode.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ACC;
         accr_q     <= '0;
         accc_q     <= '0;
         cnt_q      <= '0;
         recv_rdy_q <= 1'b1;
         send_val_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         accr_q     <= accr_d;
         accc_q     <= accc_d;
         cnt_q      <= cnt_d;
         recv_rdy_q <= (state_d == ACC);
         send_val_q <= (state_d == DONE);
      end
   end

   assign io.recv_rdy = recv_rdy_q;
   assign io.send_val = send_val_q;
   assign io.sr       = accr_q;
   assign io.sc       = accc_q;
   assign io.send_cnt = cnt_q;
endmodule
`default_nettype wire

// File: doc/fp_cmac_accumulator.md
# fp_cmac_accumulator

Streaming complex accumulator that sits directly downstream of the fixed-point complex multiplier. It sums a block of complex products (real/imaginary, two's-complement fixed point) into one complex result for correlation and FIR-style dot products. Products arrive over a val/rdy stream. The block emits one sum per block of `len` products, or fewer if `recv_last` is asserted, with optional saturation.

## Interface
- `n`, 32, bit width of every data word (signed two's complement; fixed-point format is pass-through, addition is format-agnostic)
- `len`, 8, maximum products per block (≥1)
- `sat`, 1, 1 = saturating add, 0 = wrapping add
- `cw`, $clog2(len+1), width of the term count
- `clk` in 1 clock; all state updates on rising edge
- `reset` in 1 synchronous, active-high reset; clock `clk`
- `recv_val` in 1 input product valid
- `recv_rdy` out 1 block can accept a product
- `recv_last` in 1 qualifies the current product as the final one of the block
- `xr` in n real part of product
- `xc` in n imaginary part of product
- `send_val` out 1 result valid
- `send_rdy` in 1 downstream accepts result
- `sr` out n accumulated real sum
- `sc` out n accumulated imaginary sum
- `send_cnt` out cw number of products in the emitted sum

## Operation
- Two states:
  - ACC: `recv_rdy`=1, `send_val`=0.
  - DONE: `recv_rdy`=0, `send_val`=1.
- Registers: `accr`, `accc` (n bits each), `cnt` (cw bits), state.
- `sr`=`accr`, `sc`=`accc`, `send_cnt`=`cnt` at all times. These are only meaningful while `send_val`=1 and are held stable throughout DONE.
- ACC, input fire (`recv_val & recv_rdy`):
  - `accr` <= add(`accr`, `xr`); `accc` <= add(`accc`, `xc`); `cnt` <= `cnt`+1.
  - If `cnt`+1 == `len` or `recv_last`=1, go to DONE.
- ACC, no fire: all registers hold. `recv_last` is ignored when `recv_val`=0.
- DONE with `send_rdy`=1: `accr`, `accc`, `cnt` <= 0; go to ACC.
- DONE with `send_rdy`=0: hold everything, including outputs.
- add(a, b), `sat`=1: n-bit two's-complement sum. If a and b have equal sign bits and the sum's sign differs, clamp to 2^(n-1)-1 (positive overflow) or -2^(n-1) (negative overflow). Real and imaginary parts saturate independently.
- add(a, b), `sat`=0: plain n-bit wrap.
- Partial sums accumulate saturated values. Once clamped, a sum can move back toward zero on later terms.

## Timing
- Reset values: state=ACC, `accr`=`accc`=0, `cnt`=0. Therefore `recv_rdy`=1, `send_val`=0, `sr`=`sc`=0, `send_cnt`=0.
- Latency: `send_val` rises on the cycle after the final product's fire edge.
- Throughput: at most one product per cycle. A block of k products occupies k cycles of ACC plus ≥1 cycle of DONE, so the full-rate period is `len`+1 cycles.
- `recv_rdy` is low for every DONE cycle. The result-accept edge and the next product's fire cannot coincide. The first product of the next block can fire on the cycle after acceptance.
- `recv_last` on the first product emits a 1-term sum (`send_cnt`=1).
- `recv_last` coinciding with `cnt`+1==`len`: single transition to DONE, `send_cnt`=`len`.
- `len`=1: every fire goes to DONE.
- `cnt` never exceeds `len`. A zero-term result is never emitted.
- Reset asserted in any state, including mid-block or in DONE with a pending result: the partial sum and pending result are discarded. Reset values apply on the next cycle, with `reset` taking priority over fire or accept that cycle.
- Inputs `xr`, `xc`, `recv_last` are sampled only on fire. Upstream may change them freely otherwise.

## Test plan
- n=32, len=4, sat=1; products (0x00010000, 0xFFFF0000) ×4, `send_rdy`=1 → one result `sr`=0x00040000, `sc`=0xFFFC0000, `send_cnt`=4. `send_val` high exactly one cycle, on the cycle after the 4th fire.
- len=8; 3 products xr=1,2,3 (xc=0), `recv_last` on the 3rd → `sr`=6, `sc`=0, `send_cnt`=3. Next block starts from 0.
- Back-pressure: `send_rdy`=0 for 5 cycles in DONE → `recv_rdy`=0 and `sr`/`sc`/`send_cnt` stable throughout. Result accepted on the cycle `send_rdy`=1; `recv_rdy`=1 the next cycle.
- Saturation, sat=1, len=2: xr = 0x7FFF0000, 0x7FFF0000 → `sr`=0x7FFFFFFF. xc = 0x80000000, 0xFFFFFFFF → `sc`=0x80000000. With sat=0, the same inputs give `sr`=0xFFFE0000 and `sc`=0x7FFFFFFF.
- Reset mid-block: 2 of 4 products fired, then `reset` for 1 cycle → outputs return to 0 and `cnt`=0. Four new products of value 1 → `sr`=4 (no residue).
- Random stream: random val/rdy gaps, random `recv_last`, 1000 products → every result matches a scoreboard saturating sum, with correct `send_cnt` and no lost or duplicated products.
